// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : uart_pkg                                                  |
// | Purpose  : Definitions shared by the UART receiver and transmitter:  |
// |            receiver FSM state type, data width and default bit rate. |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package uart_pkg;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_DEFAULT_RATE = 434;  // 115200 baud at 50 MHz

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : uart_rx_fifo                                              |
// | Purpose  : First-word-fall-through FIFO for received bytes.          |
// | Ports    : clk, rst_n      - clock, async active-low reset           |
// |            push, din       - write request and data                  |
// |            pop             - read request (ignored when empty)       |
// |            dout            - storage at the read pointer             |
// |            count           - occupancy                               |
// |            empty, full     - status                                  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wptr == rptr);
  // Extra pointer MSB separates full from empty when the indices match.
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count = wptr - rptr;
  assign dout  = mem[rptr[AW-1:0]];

  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wptr[AW-1:0]] <= din;
        wptr              <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : uart_rx                                                   |
// | Purpose  : 8N1 UART receiver with mid-bit sampling and a receive     |
// |            FIFO exposing head byte, occupancy and sticky errors.     |
// | Ports    : clk, rst_n      - clock, async active-low reset           |
// |            rx              - serial input (asynchronous, idles high) |
// |            rd              - pop FIFO head                           |
// |            clr_err         - clear frame_err / overrun               |
// |            data_out        - FIFO head byte (valid when data_av)     |
// |            data_av         - FIFO not empty                          |
// |            count           - FIFO occupancy                          |
// |            frame_err       - sticky: stop bit sampled low            |
// |            overrun         - sticky: byte dropped, FIFO full         |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module uart_rx
  import uart_pkg::*;
#(
  parameter int RATE_FREQ_BAUD = UART_DEFAULT_RATE,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx,
  input  logic                          rd,
  input  logic                          clr_err,
  output logic [UART_DATA_BITS-1:0]     data_out,
  output logic                          data_av,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          frame_err,
  output logic                          overrun
);

  localparam int CW   = $clog2(RATE_FREQ_BAUD);
  localparam int BW   = $clog2(UART_DATA_BITS);
  localparam int HALF = RATE_FREQ_BAUD / 2;

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(RATE_FREQ_BAUD - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(UART_DATA_BITS - 1);

  uart_rx_state_t state, state_next;

  logic                      sync1, sync2, prev;
  logic                      fall;
  logic [CW-1:0]             cyc, cyc_next;
  logic [BW-1:0]             bit_cnt, bit_next;
  logic [UART_DATA_BITS-1:0] shreg, shreg_next;
  logic                      push_set, fe_set, ovr_set;
  logic                      push_q, fe_q, ovr_q;
  logic                      fifo_full, fifo_empty;

  // Two-stage synchronizer plus one stage of history for edge detection.
  // Resetting to 1 (idle level) avoids a false start edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= rx;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign fall = prev && !sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cyc     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      push_q  <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state   <= state_next;
      cyc     <= cyc_next;
      bit_cnt <= bit_next;
      shreg   <= shreg_next;
      push_q  <= push_set;
      fe_q    <= fe_set;
      ovr_q   <= ovr_set;
    end
  end

  always_comb begin
    state_next = state;
    cyc_next   = cyc + 1'b1;
    bit_next   = bit_cnt;
    shreg_next = shreg;
    push_set   = 1'b0;
    fe_set     = 1'b0;
    ovr_set    = 1'b0;
    case (state)
      ST_IDLE: begin
        cyc_next = '0;
        if (fall) begin
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (cyc == HALF_LAST) begin
          cyc_next   = '0;
          bit_next   = '0;
          // A high line at mid-start is a glitch, silently ignored.
          state_next = sync2 ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cyc == BIT_LAST) begin
          cyc_next   = '0;
          shreg_next = {sync2, shreg[UART_DATA_BITS-1:1]};
          bit_next   = bit_cnt + 1'b1;
          if (bit_cnt == DATA_LAST) begin
            state_next = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (cyc == BIT_LAST) begin
          cyc_next   = '0;
          state_next = ST_IDLE;
          if (!sync2) begin
            fe_set = 1'b1;
          end else if (!fifo_full || rd) begin
            push_set = 1'b1;
          end else begin
            ovr_set = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Set has priority over clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (fe_q)         frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
      if (ovr_q)        overrun   <= 1'b1;
      else if (clr_err) overrun   <= 1'b0;
    end
  end

  // shreg is stable until the next frame's first data sample, so it can
  // feed the FIFO directly during the registered push cycle.
  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_q),
    .din   (shreg),
    .pop   (rd),
    .dout  (data_out),
    .count (count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign data_av = !fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_uart_rx                                                |
// | Purpose  : Self-checking bench for uart_rx (16 cycles/bit, depth 4). |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_uart_rx;

  localparam int R = 16;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       rd;
  logic       clr_err;
  logic [7:0] data_out;
  logic       data_av;
  logic [2:0] count;
  logic       frame_err;
  logic       overrun;

  int tests = 0;
  int fails = 0;

  // Reference model: queue of stored bytes plus sticky flags.
  logic [7:0] mq[$];
  logic       m_fe;
  logic       m_ovr;

  uart_rx #(
    .RATE_FREQ_BAUD (R),
    .FIFO_DEPTH     (D)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rd        (rd),
    .clr_err   (clr_err),
    .data_out  (data_out),
    .data_av   (data_av),
    .count     (count),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Starts and ends on a falling clock edge; each bit held R cycles.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (R) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (R) @(negedge clk);
    end
    rx = stop;
    repeat (R) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic pop_byte();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  function automatic void model_frame(input logic [7:0] b, input logic stop);
    if (!stop)                  m_fe = 1'b1;
    else if (mq.size() < D)     mq.push_back(b);
    else                        m_ovr = 1'b1;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; rx = 1'b1; rd = 1'b0; clr_err = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (data_out !== 8'h00) begin fails++; $display("FAIL reset_data_out got %h want 00", data_out); end
    tests++; if (data_av !== 1'b0) begin fails++; $display("FAIL reset_data_av got %b want 0", data_av); end
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d want 0", count); end
    tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun got %b want 0", overrun); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_latency_a5();
    fork
      send_frame(8'hA5, 1'b1);
      begin
        repeat (155) @(posedge clk);
        #1;
        tests++; if (data_av !== 1'b0) begin fails++; $display("FAIL early_data_av got %b want 0", data_av); end
        @(posedge clk);
        #1;
        tests++; if (data_av !== 1'b1) begin fails++; $display("FAIL a5_data_av got %b want 1", data_av); end
        tests++; if (data_out !== 8'hA5) begin fails++; $display("FAIL a5_data_out got %h want a5", data_out); end
        tests++; if (count !== 3'd1) begin fails++; $display("FAIL a5_count got %0d want 1", count); end
      end
    join
    pop_byte();
    tests++; if (data_av !== 1'b0) begin fails++; $display("FAIL a5_pop_data_av got %b want 0", data_av); end
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL a5_pop_count got %0d want 0", count); end
  endtask

  task automatic test_glitch();
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL glitch_count got %0d want 0", count); end
    tests++; if ({frame_err, overrun} !== 2'b00) begin fails++; $display("FAIL glitch_flags got %b want 00", {frame_err, overrun}); end
    send_frame(8'h3C, 1'b1);
    repeat (2) @(negedge clk);
    tests++; if (data_out !== 8'h3C) begin fails++; $display("FAIL glitch_next_data got %h want 3c", data_out); end
    tests++; if (count !== 3'd1) begin fails++; $display("FAIL glitch_next_count got %0d want 1", count); end
    pop_byte();
  endtask

  task automatic test_frame_err();
    send_frame(8'h55, 1'b0);
    repeat (2) @(negedge clk);
    tests++; if (frame_err !== 1'b1) begin fails++; $display("FAIL fe_set got %b want 1", frame_err); end
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL fe_count got %0d want 0", count); end
    pulse_clr();
    tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL fe_clear got %b want 0", frame_err); end
  endtask

  task automatic test_overrun();
    for (int v = 1; v <= 5; v++) send_frame(8'(v), 1'b1);
    repeat (2) @(negedge clk);
    tests++; if (count !== 3'd4) begin fails++; $display("FAIL ovr_count got %0d want 4", count); end
    tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_flag got %b want 1", overrun); end
    for (int v = 1; v <= 4; v++) begin
      tests++; if (data_out !== 8'(v)) begin fails++; $display("FAIL ovr_pop%0d got %h want %h", v, data_out, 8'(v)); end
      pop_byte();
    end
    tests++; if (data_av !== 1'b0) begin fails++; $display("FAIL ovr_drained got %b want 0", data_av); end
    pulse_clr();
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_clear got %b want 0", overrun); end
  endtask

  task automatic test_rd_at_stop();
    logic [7:0] fill [4];
    logic [7:0] exp_seq [4];
    for (int i = 0; i < 4; i++) begin
      fill[i] = 8'($urandom_range(0, 255));
      send_frame(fill[i], 1'b1);
    end
    fork
      send_frame(8'h99, 1'b1);
      begin
        repeat (154) @(negedge clk);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
      end
    join
    repeat (2) @(negedge clk);
    tests++; if (count !== 3'd4) begin fails++; $display("FAIL rdstop_count got %0d want 4", count); end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL rdstop_overrun got %b want 0", overrun); end
    exp_seq[0] = fill[1]; exp_seq[1] = fill[2]; exp_seq[2] = fill[3]; exp_seq[3] = 8'h99;
    for (int i = 0; i < 4; i++) begin
      tests++; if (data_out !== exp_seq[i]) begin fails++; $display("FAIL rdstop_pop%0d got %h want %h", i, data_out, exp_seq[i]); end
      pop_byte();
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] b;
    send_frame(8'h42, 1'b1);
    rx = 1'b0;
    repeat (60) @(negedge clk);
    rst_n = 1'b0;
    #2;
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL midrst_count got %0d want 0", count); end
    tests++; if (data_av !== 1'b0) begin fails++; $display("FAIL midrst_data_av got %b want 0", data_av); end
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    b = 8'($urandom_range(0, 255));
    send_frame(b, 1'b1);
    repeat (2) @(negedge clk);
    tests++; if (data_out !== b) begin fails++; $display("FAIL midrst_next_data got %h want %h", data_out, b); end
    tests++; if (count !== 3'd1) begin fails++; $display("FAIL midrst_next_count got %0d want 1", count); end
    pop_byte();
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic       stop;
    logic [7:0] e;
    mq.delete();
    m_fe = 1'b0;
    m_ovr = 1'b0;
    for (int it = 0; it < 12; it++) begin
      b    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 4) != 0);
      send_frame(b, stop);
      repeat ($urandom_range(1, 6)) @(negedge clk);
      model_frame(b, stop);
      tests++; if (int'(count) != mq.size()) begin fails++; $display("FAIL rnd%0d_count got %0d want %0d", it, count, mq.size()); end
      tests++; if (frame_err !== m_fe) begin fails++; $display("FAIL rnd%0d_frame_err got %b want %b", it, frame_err, m_fe); end
      tests++; if (overrun !== m_ovr) begin fails++; $display("FAIL rnd%0d_overrun got %b want %b", it, overrun, m_ovr); end
      if ($urandom_range(0, 2) == 0) begin
        while (mq.size() > 0) begin
          e = mq.pop_front();
          tests++; if (data_out !== e) begin fails++; $display("FAIL rnd%0d_pop got %h want %h", it, data_out, e); end
          pop_byte();
        end
      end
      if ($urandom_range(0, 3) == 0) begin
        pulse_clr();
        m_fe = 1'b0;
        m_ovr = 1'b0;
      end
    end
    while (mq.size() > 0) begin
      e = mq.pop_front();
      tests++; if (data_out !== e) begin fails++; $display("FAIL rnd_drain got %h want %h", data_out, e); end
      pop_byte();
    end
    tests++; if (data_av !== 1'b0) begin fails++; $display("FAIL rnd_empty got %b want 0", data_av); end
    pulse_clr();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_latency_a5();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_rd_at_stop();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
